// File: rtl/bus_fabric.sv
// Single-master system-bus interconnect: decodes the slot-select address field, holds the
// request stable on the bus while the slave inserts wait states, and answers unmapped or stalled accesses with an error.
module bus_fabric #(
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = 28,
    parameter int SEL_W    = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    input  logic [1:0]               hb_i,
    output logic                     ready_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic [7:0]               err_cnt_o,
    output logic [31:0]              bus_addr_o,
    output logic [31:0]              bus_wdata_o,
    output logic                     bus_we_o,
    output logic [1:0]               bus_hb_o,
    output logic [N_SLAVES-1:0]      cs_o,
    input  logic [32*N_SLAVES-1:0]   slv_rdata_i,
    input  logic [N_SLAVES-1:0]      slv_ready_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic [SEL_W-1:0]    sel;
    logic [N_SLAVES-1:0] sel_onehot;
    logic                slot_ready;
    logic [31:0]         slot_rdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sel = addr_i[SEL_LSB +: SEL_W];

    // A select value beyond the last slot yields an all-zero vector, which marks the access unmapped.
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < N_SLAVES; k++)
            sel_onehot[k] = (sel == SEL_W'(k));
    end

    always_comb begin
        slot_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (cs_o[k])
                slot_rdata = slv_rdata_i[32*k +: 32];
    end

    assign slot_ready = |(slv_ready_i & cs_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_o     <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            err_cnt_o   <= '0;
            cs_o        <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_we_o    <= 1'b0;
            bus_hb_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (|sel_onehot) begin
                            bus_addr_o  <= addr_i;
                            bus_wdata_o <= wdata_i;
                            bus_we_o    <= we_i;
                            bus_hb_o    <= hb_i;
                            cs_o        <= sel_onehot;
                            cnt         <= '0;
                            state       <= ACCESS;
                        end else begin
                            ready_o   <= 1'b1;
                            err_o     <= 1'b1;
                            rdata_o   <= '0;
                            err_cnt_o <= sat_inc(err_cnt_o);
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (slot_ready) begin
                        ready_o <= 1'b1;
                        err_o   <= 1'b0;
                        rdata_o <= slot_rdata;
                        cs_o    <= '0;
                        state   <= RESP;
                    end else if (cnt + 8'd1 == 8'(TIMEOUT)) begin
                        ready_o   <= 1'b1;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                        cs_o      <= '0;
                        cnt       <= cnt + 8'd1;
                        err_cnt_o <= sat_inc(err_cnt_o);
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    rdata_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
